// File: rtl/cache_data_array_mp.sv
// Multi-port cache data array: one read/write port, NUM_RD read-only ports, per-line valid
// bits with bulk invalidate. Requests sampled at edge N produce results and commits at edge N+1.
module cache_data_array_mp #(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_WMASKS  = 32,
    parameter int NUM_RD      = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic                           clk0,
    input  logic                           rstb0,
    input  logic                           csb0,
    input  logic                           web0,
    input  logic [NUM_WMASKS-1:0]          wmask0,
    input  logic [ADDR_WIDTH-1:0]          addr0,
    input  logic [DATA_WIDTH-1:0]          din0,
    output logic [DATA_WIDTH-1:0]          dout0,
    output logic                           dvld0,
    output logic                           hit0,
    input  logic [NUM_RD-1:0]              csb1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   addr1,
    output logic [NUM_RD*DATA_WIDTH-1:0]   dout1,
    output logic [NUM_RD-1:0]              dvld1,
    output logic [NUM_RD-1:0]              hit1,
    input  logic                           inv_all
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NP    = NUM_RD + 1;

    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0]             valid_d;

    logic                         wr_pend_q;
    logic [ADDR_WIDTH-1:0]        wr_addr_q;
    logic [NUM_WMASKS-1:0]        wr_mask_q;
    logic [DATA_WIDTH-1:0]        wr_data_q;
    logic                         inv_pend_q;
    logic                         rd0_pend_q;
    logic [ADDR_WIDTH-1:0]        rd0_addr_q;
    logic [NUM_RD-1:0]            rd1_pend_q;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd1_addr_q;

    logic                         wr_live;
    logic [DATA_WIDTH-1:0]        wr_line;
    logic [ADDR_WIDTH-1:0]        rd_addr [NP];
    logic [DATA_WIDTH-1:0]        rd_line [NP];
    logic                         rd_hit  [NP];

    // A write with an all-zero mask is dropped entirely, so it never sets valid.
    assign wr_live = wr_pend_q && (|wr_mask_q);

    always_comb begin
        wr_line = mem[wr_addr_q];
        for (int b = 0; b < NUM_WMASKS; b++) begin
            if (wr_mask_q[b]) wr_line[8*b +: 8] = wr_data_q[8*b +: 8];
        end
    end

    // Reads see the array before this edge's commit; write-first mode forwards the merged line.
    always_comb begin
        rd_addr[0] = rd0_addr_q;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k+1] = rd1_addr_q[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int p = 0; p < NP; p++) begin
            rd_hit[p]  = valid_q[rd_addr[p]];
            rd_line[p] = mem[rd_addr[p]];
            if ((WRITE_FIRST != 0) && wr_live && (wr_addr_q == rd_addr[p])) begin
                rd_hit[p]  = 1'b1;
                rd_line[p] = wr_line;
            end
            if (!rd_hit[p]) rd_line[p] = '0;
        end
    end

    // Invalidate clears first so a coinciding write commit leaves its line valid.
    always_comb begin
        valid_d = valid_q;
        if (inv_pend_q) valid_d = '0;
        if (wr_live) valid_d[wr_addr_q] = 1'b1;
    end

    always_ff @(posedge clk0) begin
        if (wr_live) mem[wr_addr_q] <= wr_line;
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            valid_q    <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_mask_q  <= '0;
            wr_data_q  <= '0;
            inv_pend_q <= 1'b0;
            rd0_pend_q <= 1'b0;
            rd0_addr_q <= '0;
            rd1_pend_q <= '0;
            rd1_addr_q <= '0;
            dout0      <= '0;
            dvld0      <= 1'b0;
            hit0       <= 1'b0;
            dout1      <= '0;
            dvld1      <= '0;
            hit1       <= '0;
        end else begin
            valid_q    <= valid_d;
            inv_pend_q <= inv_all;
            wr_pend_q  <= !csb0 && !web0;
            rd0_pend_q <= !csb0 && (web0 || (WRITE_FIRST != 0));
            if (!csb0) begin
                wr_addr_q  <= addr0;
                wr_mask_q  <= wmask0;
                wr_data_q  <= din0;
                rd0_addr_q <= addr0;
            end
            dvld0 <= rd0_pend_q;
            if (rd0_pend_q) begin
                dout0 <= rd_line[0];
                hit0  <= rd_hit[0];
            end
            rd1_pend_q <= ~csb1;
            for (int k = 0; k < NUM_RD; k++) begin
                if (!csb1[k]) rd1_addr_q[k*ADDR_WIDTH +: ADDR_WIDTH] <= addr1[k*ADDR_WIDTH +: ADDR_WIDTH];
                dvld1[k] <= rd1_pend_q[k];
                if (rd1_pend_q[k]) begin
                    dout1[k*DATA_WIDTH +: DATA_WIDTH] <= rd_line[k+1];
                    hit1[k] <= rd_hit[k+1];
                end
            end
        end
    end

endmodule
